// File: rtl/arch_map_mw_pkg.sv
// Shared types and constants for the multi-retire architectural map table.
package arch_map_mw_pkg;

  localparam int NUM_ARCH     = 32;
  localparam int NUM_PR       = 64;
  localparam int PR_W         = $clog2(NUM_PR);
  localparam int AR_W         = 5;
  localparam int RETIRE_WIDTH = 2;
  localparam int COPY_WIDTH   = 8;
  localparam int ZERO_REG     = 31;
  localparam int NUM_BEATS    = NUM_ARCH / COPY_WIDTH;
  localparam int PTR_W        = $clog2(NUM_BEATS);
  localparam int CW_W         = $clog2(COPY_WIDTH);

  // Committed map: entry i holds the physical register of arch register i.
  typedef logic [NUM_ARCH-1:0][PR_W-1:0] ARCH_MAP_t;

  typedef enum logic [1:0] {
    AM_IDLE = 2'd0,
    AM_COPY = 2'd1,
    AM_DONE = 2'd2
  } ARCH_MAP_STATE_t;

  // Retire packet as produced by the ROB; Told_idx is consumed by the free list.
  typedef struct packed {
    logic [AR_W-1:0] dest_idx;
    logic [PR_W-1:0] T_idx;
    logic [PR_W-1:0] Told_idx;
  } retire_pkt_t;

  // Identity map: arch register i starts in physical register i.
  function automatic ARCH_MAP_t arch_map_reset_f();
    ARCH_MAP_t m;
    for (int i = 0; i < NUM_ARCH; i++) begin
      m[i] = PR_W'(i);
    end
    return m;
  endfunction

  localparam ARCH_MAP_t ARCH_MAP_RESET = arch_map_reset_f();

endpackage

// File: rtl/arch_map_retire_merge.sv
// Combinational priority merge of up to RETIRE_WIDTH retirements into the map.
// Slots are applied oldest first, so the youngest slot wins on equal dest.
module arch_map_retire_merge
  import arch_map_mw_pkg::*;
(
  input  ARCH_MAP_t                      map_in,
  input  logic [RETIRE_WIDTH-1:0]        retire_en,
  input  logic [RETIRE_WIDTH*AR_W-1:0]   retire_dest_idx,
  input  logic [RETIRE_WIDTH*PR_W-1:0]   retire_T_idx,
  output ARCH_MAP_t                      map_out
);

  // Apply each enabled slot in order; the zero register is never remapped.
  always_comb begin
    map_out = map_in;
    for (int s = 0; s < RETIRE_WIDTH; s++) begin
      if (retire_en[s] &&
          (retire_dest_idx[s*AR_W +: AR_W] != AR_W'(ZERO_REG))) begin
        map_out[retire_dest_idx[s*AR_W +: AR_W]] = retire_T_idx[s*PR_W +: PR_W];
      end
    end
  end

endmodule

// File: rtl/arch_map_mw.sv
// Multi-retire architectural map table with beat-wise recovery copy.
// Copy handshake: a beat transfers on a rising edge where copy_valid, copy_ready
// and en are all high; while copy_valid is high and the beat has not transferred,
// copy_base_idx and copy_T_idx hold stable and copy_valid stays high.
module arch_map_mw
  import arch_map_mw_pkg::*;
(
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          en,
  input  logic [RETIRE_WIDTH-1:0]       retire_en,
  input  logic [RETIRE_WIDTH*AR_W-1:0]  retire_dest_idx,
  input  logic [RETIRE_WIDTH*PR_W-1:0]  retire_T_idx,
  input  logic                          rollback_req,
  output logic                          copy_valid,
  input  logic                          copy_ready,
  output logic [AR_W-1:0]               copy_base_idx,
  output logic [COPY_WIDTH*PR_W-1:0]    copy_T_idx,
  output logic                          rollback_done,
  output logic                          busy,
  output logic [NUM_ARCH*PR_W-1:0]      arch_map_out
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_BEATS - 1);

  ARCH_MAP_STATE_t  state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  ARCH_MAP_t        map_q, map_d, map_merged;
  logic [AR_W-1:0]  base_idx;

  arch_map_retire_merge u_merge (
    .map_in          (map_q),
    .retire_en       (retire_en),
    .retire_dest_idx (retire_dest_idx),
    .retire_T_idx    (retire_T_idx),
    .map_out         (map_merged)
  );

  assign base_idx = {ptr_q, {CW_W{1'b0}}};

  // Next state, beat pointer and map; en low leaves everything as is.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    map_d   = map_q;
    if (en) begin
      case (state_q)
        AM_IDLE: begin
          // Retires in the rollback cycle still commit before the copy starts.
          map_d = map_merged;
          if (rollback_req) begin
            state_d = AM_COPY;
            ptr_d   = '0;
          end
        end
        AM_COPY: begin
          if (copy_ready) begin
            if (ptr_q == LAST_PTR) begin
              state_d = AM_DONE;
              ptr_d   = '0;
            end else begin
              ptr_d = ptr_q + 1'b1;
            end
          end
        end
        AM_DONE: begin
          state_d = AM_IDLE;
          ptr_d   = '0;
        end
        default: begin
          state_d = AM_IDLE;
          ptr_d   = '0;
        end
      endcase
    end
  end

  // State, pointer and committed map registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= AM_IDLE;
      ptr_q   <= '0;
      map_q   <= ARCH_MAP_RESET;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      map_q   <= map_d;
    end
  end

  // Beat payload is a window of the frozen map selected by the pointer.
  always_comb begin
    copy_valid    = 1'b0;
    copy_base_idx = '0;
    copy_T_idx    = '0;
    if (state_q == AM_COPY) begin
      copy_valid    = 1'b1;
      copy_base_idx = base_idx;
      for (int k = 0; k < COPY_WIDTH; k++) begin
        copy_T_idx[k*PR_W +: PR_W] = map_q[base_idx | AR_W'(k)];
      end
    end
  end

  assign rollback_done = (state_q == AM_DONE);
  assign busy          = (state_q != AM_IDLE);
  assign arch_map_out  = map_q;

  // The ROB is flushed during recovery, so no retires or new requests arrive.
  a_no_retire_when_busy : assert property (@(posedge clock) disable iff (!reset_n)
    (state_q != AM_IDLE) |-> (retire_en == '0));
  a_no_req_when_busy : assert property (@(posedge clock) disable iff (!reset_n)
    (state_q != AM_IDLE) |-> !rollback_req);

endmodule

// File: tb/tb_arch_map_mw.sv
// Testbench for arch_map_mw: table-driven retire vectors plus rollback sequences
// whose copy beats are checked against an expected-beat queue.
module tb_arch_map_mw;
  import arch_map_mw_pkg::*;

  localparam int BEAT_W = AR_W + COPY_WIDTH*PR_W;

  logic                          clock;
  logic                          reset_n;
  logic                          en;
  logic [RETIRE_WIDTH-1:0]       retire_en;
  logic [RETIRE_WIDTH*AR_W-1:0]  retire_dest_idx;
  logic [RETIRE_WIDTH*PR_W-1:0]  retire_T_idx;
  logic                          rollback_req;
  logic                          copy_valid;
  logic                          copy_ready;
  logic [AR_W-1:0]               copy_base_idx;
  logic [COPY_WIDTH*PR_W-1:0]    copy_T_idx;
  logic                          rollback_done;
  logic                          busy;
  logic [NUM_ARCH*PR_W-1:0]      arch_map_out;

  int checks = 0;
  int errors = 0;

  logic [PR_W-1:0]   model_map [NUM_ARCH];
  logic [BEAT_W-1:0] exp_q[$];

  typedef struct {
    logic [1:0]      ren;
    logic [AR_W-1:0] d0;
    logic [PR_W-1:0] t0;
    logic [AR_W-1:0] d1;
    logic [PR_W-1:0] t1;
    int              ia;
    logic [PR_W-1:0] va;
    int              ib;
    logic [PR_W-1:0] vb;
  } vec_t;

  vec_t vecs [6];

  arch_map_mw dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .en              (en),
    .retire_en       (retire_en),
    .retire_dest_idx (retire_dest_idx),
    .retire_T_idx    (retire_T_idx),
    .rollback_req    (rollback_req),
    .copy_valid      (copy_valid),
    .copy_ready      (copy_ready),
    .copy_base_idx   (copy_base_idx),
    .copy_T_idx      (copy_T_idx),
    .rollback_done   (rollback_done),
    .busy            (busy),
    .arch_map_out    (arch_map_out)
  );

  // Clock and watchdog
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [PR_W-1:0] dut_map(input int i);
    return arch_map_out[i*PR_W +: PR_W];
  endfunction

  task automatic chk_map(input string name);
    int bad_idx;
    bad_idx = -1;
    for (int i = 0; i < NUM_ARCH; i++) begin
      if (bad_idx < 0 && dut_map(i) !== model_map[i]) bad_idx = i;
    end
    checks++;
    if (bad_idx >= 0) begin
      errors++;
      $display("FAIL %s: map[%0d] got %0d expected %0d", name, bad_idx,
               dut_map(bad_idx), model_map[bad_idx]);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_ARCH; i++) model_map[i] = PR_W'(i);
  endtask

  task automatic model_retire(input logic [1:0] ren, input logic [AR_W-1:0] d0,
                              input logic [PR_W-1:0] t0, input logic [AR_W-1:0] d1,
                              input logic [PR_W-1:0] t1);
    if (ren[0] && d0 != AR_W'(ZERO_REG)) model_map[d0] = t0;
    if (ren[1] && d1 != AR_W'(ZERO_REG)) model_map[d1] = t1;
  endtask

  task automatic drive_retire(input logic [1:0] ren, input logic [AR_W-1:0] d0,
                              input logic [PR_W-1:0] t0, input logic [AR_W-1:0] d1,
                              input logic [PR_W-1:0] t1);
    retire_en       = ren;
    retire_dest_idx = {d1, d0};
    retire_T_idx    = {t1, t0};
  endtask

  // Expected beats come from the bench's own model of the committed map.
  task automatic push_beats();
    logic [BEAT_W-1:0] item;
    for (int b = 0; b < NUM_BEATS; b++) begin
      item = '0;
      item[BEAT_W-1 -: AR_W] = AR_W'(b * COPY_WIDTH);
      for (int k = 0; k < COPY_WIDTH; k++) begin
        item[k*PR_W +: PR_W] = model_map[b*COPY_WIDTH + k];
      end
      exp_q.push_back(item);
    end
  endtask

  // Rollback driver: optional same-cycle retire r2->T33, optional stall on a beat.
  task automatic run_rollback(input string tag, input bit with_retire,
                              input int stall_beat, input int stall_cycles);
    int cyc;
    int beat;
    int stall_cnt;
    int done_cyc;
    logic [BEAT_W-1:0] item;
    if (with_retire) begin
      drive_retire(2'b01, 5'd2, 6'd33, 5'd0, 6'd0);
      model_retire(2'b01, 5'd2, 6'd33, 5'd0, 6'd0);
    end
    push_beats();
    rollback_req = 1'b1;
    copy_ready   = 1'b1;
    tick();
    rollback_req = 1'b0;
    drive_retire(2'b00, 5'd0, 6'd0, 5'd0, 6'd0);
    cyc       = 1;
    beat      = 0;
    stall_cnt = 0;
    done_cyc  = -1;
    while (cyc <= 40 && done_cyc < 0) begin
      if (rollback_done) begin
        done_cyc = cyc;
      end else begin
        chk({tag, " copy_valid"}, 64'(copy_valid), 64'd1);
        if (with_retire && cyc == 1) begin
          chk({tag, " beat0 k2"}, 64'(copy_T_idx[2*PR_W +: PR_W]), 64'd33);
        end
        if (copy_valid && exp_q.size() > 0) begin
          item = exp_q[0];
          chk({tag, " base"}, 64'(copy_base_idx), 64'(item[BEAT_W-1 -: AR_W]));
          chk({tag, " payload"}, 64'(copy_T_idx), 64'(item[COPY_WIDTH*PR_W-1:0]));
          if (beat == stall_beat && stall_cnt < stall_cycles) begin
            copy_ready = 1'b0;
            stall_cnt++;
          end else begin
            copy_ready = 1'b1;
            void'(exp_q.pop_front());
            beat++;
          end
        end
        tick();
        cyc++;
      end
    end
    copy_ready = 1'b1;
    chk({tag, " done cycle"}, 64'(done_cyc), 64'(NUM_BEATS + 1 + stall_cycles));
    chk({tag, " beats left"}, 64'(exp_q.size()), 64'd0);
    chk({tag, " busy at done"}, 64'(busy), 64'd1);
    tick();
    chk({tag, " done pulse width"}, 64'(rollback_done), 64'd0);
    chk({tag, " busy after"}, 64'(busy), 64'd0);
    chk_map({tag, " map after"});
    exp_q.delete();
  endtask

  initial begin
    vecs[0] = '{2'b11, 5'd3,  6'd40, 5'd5,  6'd41, 3,  6'd40, 5,  6'd41};
    vecs[1] = '{2'b11, 5'd7,  6'd50, 5'd7,  6'd51, 7,  6'd51, 3,  6'd40};
    vecs[2] = '{2'b11, 5'd31, 6'd60, 5'd4,  6'd20, 31, 6'd31, 4,  6'd20};
    vecs[3] = '{2'b10, 5'd10, 6'd13, 5'd9,  6'd12, 9,  6'd12, 10, 6'd10};
    vecs[4] = '{2'b11, 5'd3,  6'd44, 5'd31, 6'd45, 3,  6'd44, 31, 6'd31};
    vecs[5] = '{2'b00, 5'd1,  6'd55, 5'd6,  6'd56, 1,  6'd1,  6,  6'd6};

    reset_n      = 1'b0;
    en           = 1'b1;
    rollback_req = 1'b0;
    copy_ready   = 1'b0;
    drive_retire(2'b00, 5'd0, 6'd0, 5'd0, 6'd0);
    model_reset();

    // Reset state
    tick();
    tick();
    chk("reset copy_valid", 64'(copy_valid), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset rollback_done", 64'(rollback_done), 64'd0);
    chk("reset copy_base_idx", 64'(copy_base_idx), 64'd0);
    chk("reset copy_T_idx", 64'(copy_T_idx), 64'd0);
    chk_map("reset map");
    reset_n = 1'b1;
    tick();

    // Retire vectors
    for (int v = 0; v < 6; v++) begin
      drive_retire(vecs[v].ren, vecs[v].d0, vecs[v].t0, vecs[v].d1, vecs[v].t1);
      model_retire(vecs[v].ren, vecs[v].d0, vecs[v].t0, vecs[v].d1, vecs[v].t1);
      tick();
      drive_retire(2'b00, 5'd0, 6'd0, 5'd0, 6'd0);
      chk($sformatf("vec%0d map[%0d]", v, vecs[v].ia), 64'(dut_map(vecs[v].ia)), 64'(vecs[v].va));
      chk($sformatf("vec%0d map[%0d]", v, vecs[v].ib), 64'(dut_map(vecs[v].ib)), 64'(vecs[v].vb));
      chk_map($sformatf("vec%0d full map", v));
    end

    // en low in IDLE: retire and rollback request are both ignored
    en = 1'b0;
    drive_retire(2'b11, 5'd6, 6'd22, 5'd8, 6'd23);
    rollback_req = 1'b1;
    tick();
    rollback_req = 1'b0;
    drive_retire(2'b00, 5'd0, 6'd0, 5'd0, 6'd0);
    en = 1'b1;
    chk("en0 map[6]", 64'(dut_map(6)), 64'(model_map[6]));
    chk("en0 busy", 64'(busy), 64'd0);
    chk_map("en0 full map");

    // Random retires
    for (int r = 0; r < 8; r++) begin
      logic [1:0]      ren;
      logic [AR_W-1:0] d0, d1;
      logic [PR_W-1:0] t0, t1;
      ren = 2'($urandom_range(0, 3));
      d0  = AR_W'($urandom_range(0, NUM_ARCH - 1));
      d1  = AR_W'($urandom_range(0, NUM_ARCH - 1));
      t0  = PR_W'($urandom_range(0, NUM_PR - 1));
      t1  = PR_W'($urandom_range(0, NUM_PR - 1));
      drive_retire(ren, d0, t0, d1, t1);
      model_retire(ren, d0, t0, d1, t1);
      tick();
      drive_retire(2'b00, 5'd0, 6'd0, 5'd0, 6'd0);
      chk_map($sformatf("rand%0d map", r));
    end

    // Rollback with same-cycle retire, ready always high
    run_rollback("rb_plain", 1'b1, -1, 0);

    // Rollback with ready low for 3 cycles on beat 1
    run_rollback("rb_stall", 1'b0, 1, 3);

    // en low mid-copy, then reset mid-copy
    push_beats();
    rollback_req = 1'b1;
    copy_ready   = 1'b1;
    tick();
    rollback_req = 1'b0;
    chk("abort beat0 base", 64'(copy_base_idx), 64'd0);
    void'(exp_q.pop_front());
    tick();
    en = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk($sformatf("freeze%0d valid", c), 64'(copy_valid), 64'd1);
      chk($sformatf("freeze%0d base", c), 64'(copy_base_idx), 64'd8);
      chk($sformatf("freeze%0d payload", c), 64'(copy_T_idx),
          64'(exp_q[0][COPY_WIDTH*PR_W-1:0]));
    end
    en      = 1'b1;
    reset_n = 1'b0;
    tick();
    model_reset();
    exp_q.delete();
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort copy_valid", 64'(copy_valid), 64'd0);
    chk("abort rollback_done", 64'(rollback_done), 64'd0);
    chk("abort copy_T_idx", 64'(copy_T_idx), 64'd0);
    chk_map("abort map");
    tick();
    reset_n = 1'b1;
    begin
      int seen_done;
      seen_done = 0;
      for (int c = 0; c < 6; c++) begin
        tick();
        if (rollback_done || busy) seen_done++;
      end
      chk("abort no done pulse", 64'(seen_done), 64'd0);
    end

    // Recovery works again after the aborted copy
    run_rollback("rb_after_abort", 1'b0, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
